// File: rtl/sm4_round_seq.sv
// sm4_round_seq: runs 32 SM4 rounds (encrypt/decrypt or key expansion) over an external ssm4 unit
module sm4_round_seq #(
    parameter int ROUNDS = 32
) (
    input  logic         g_clk,
    input  logic         g_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_ks,
    input  logic         in_dec,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [4:0]   rk_idx,
    input  logic [31:0]  rk_in,
    output logic         rk_out_valid,
    output logic [4:0]   rk_out_idx,
    output logic [31:0]  rk_out,
    output logic [31:0]  fu_rs1,
    output logic [31:0]  fu_rs2,
    output logic [1:0]   fu_bs,
    output logic         fu_op_ks,
    output logic         fu_op_ed,
    input  logic [31:0]  fu_result
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    state_t       state, state_nx;
    logic [31:0]  x0, x1, x2, x3, acc;
    logic [4:0]   round;
    logic [1:0]   bs;
    logic         ks, dec, run, last, fin;
    logic [31:0]  ck;
    logic [127:0] ld;

    // CK byte j of round r is (4r + j) * 7 mod 256; 4r + j is just {r, j}
    function automatic logic [7:0] ck_byte(input logic [4:0] r, input logic [1:0] j);
        logic [7:0] n;
        n = {1'b0, r, j};
        return n * 8'd7;
    endfunction

    // Operand formation for the ssm4 unit, handshakes and next state
    always_comb begin
        run          = state == RUN;
        last         = bs == 2'd3;
        fin          = last && round == 5'(ROUNDS - 1);
        ck           = {ck_byte(round, 2'd0), ck_byte(round, 2'd1), ck_byte(round, 2'd2), ck_byte(round, 2'd3)};
        ld           = in_data ^ (in_ks ? FK : 128'd0);
        in_ready     = state == IDLE;
        out_valid    = state == DONE;
        out_data     = {x3, x2, x1, x0};
        fu_rs1       = acc;
        fu_rs2       = x1 ^ x2 ^ x3 ^ (ks ? ck : rk_in);
        fu_bs        = bs;
        fu_op_ks     = run && ks;
        fu_op_ed     = run && !ks;
        rk_idx       = run ? (dec ? 5'd31 - round : round) : 5'd0;
        rk_out_valid = run && ks && last;
        rk_out_idx   = round;
        rk_out       = fu_result;
        state_nx     = (state == IDLE && in_valid) ? RUN :
                       (run && fin)                ? DONE :
                       (state == DONE && out_ready) ? IDLE : state;
    end

    // Load on accept, chain byte steps through acc, shift the word window each round
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state <= IDLE;
            {x0, x1, x2, x3, acc} <= '0;
            round <= '0;
            bs    <= '0;
            ks    <= 1'b0;
            dec   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                {x0, x1, x2, x3} <= ld;
                acc   <= ld[127:96];
                ks    <= in_ks;
                dec   <= in_dec && !in_ks;
                round <= '0;
                bs    <= '0;
            end else if (run) begin
                if (last) begin
                    x0    <= x1;
                    x1    <= x2;
                    x2    <= x3;
                    x3    <= fu_result;
                    acc   <= x1;
                    bs    <= '0;
                    round <= round + 5'd1;
                end else begin
                    acc <= fu_result;
                    bs  <= bs + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sm4_round_seq.sv
// tb_sm4_round_seq: directed checks of sm4_round_seq against published SM4 vectors
module tb_sm4_round_seq;
    logic         g_clk = 1'b0, g_rst = 1'b1;
    logic         in_valid = 1'b0, in_ks = 1'b0, in_dec = 1'b0, out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready, out_valid, rk_out_valid, fu_op_ks, fu_op_ed;
    logic [127:0] out_data;
    logic [4:0]   rk_idx, rk_out_idx;
    logic [31:0]  rk_in, rk_out, fu_rs1, fu_rs2, fu_result;
    logic [1:0]   fu_bs;
    logic [31:0]  ks_mem [32];
    int           passed = 0, total = 0, bus_err = 0, strobes = 0;

    localparam logic [127:0] FK  = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
    localparam logic [127:0] PT  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT  = 128'h681EDF34D206965E86B3E94F536E4246;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Behavioural ssm4 unit: one S-box byte, linear transform, rotate into place, xor into rs1
    function automatic logic [31:0] ssm4(input logic [31:0] rs1, input logic [31:0] rs2,
                                         input logic [1:0] bs, input logic ks);
        logic [31:0] x, y;
        x = {24'd0, SBOX[8'(rs2 >> (8 * int'(bs)))]};
        y = ks ? (x ^ rol(x, 13) ^ rol(x, 23)) : (x ^ rol(x, 2) ^ rol(x, 10) ^ rol(x, 18) ^ rol(x, 24));
        return rs1 ^ rol(y, 8 * int'(bs));
    endfunction

    assign fu_result = ssm4(fu_rs1, fu_rs2, fu_bs, fu_op_ks);
    assign rk_in     = ks_mem[rk_idx];

    always #5 g_clk = ~g_clk;

    sm4_round_seq dut (
        .g_clk(g_clk), .g_rst(g_rst), .in_valid(in_valid), .in_ready(in_ready), .in_ks(in_ks),
        .in_dec(in_dec), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .rk_idx(rk_idx), .rk_in(rk_in), .rk_out_valid(rk_out_valid),
        .rk_out_idx(rk_out_idx), .rk_out(rk_out), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_bs(fu_bs),
        .fu_op_ks(fu_op_ks), .fu_op_ed(fu_op_ed), .fu_result(fu_result)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one job and step through RUN checking the bus every cycle; returns cycles to out_valid
    task automatic go(input logic k, input logic d, input logic [127:0] din, output int lat);
        logic [31:0]  xs [36];
        logic [127:0] s;
        logic [4:0]   er;
        int           c, r;
        s = din ^ (k ? FK : 128'd0);
        {xs[0], xs[1], xs[2], xs[3]} = s;
        in_ks = k;
        in_dec = d;
        in_data = din;
        in_valid = 1'b1;
        @(posedge g_clk); #1;
        in_valid = 1'b0;
        lat = 1;
        c = 0;
        while (!out_valid && lat < 400) begin
            r = c / 4;
            er = (d && !k) ? 5'(31 - r) : 5'(r);
            if (fu_bs !== 2'(c % 4)) bus_err++;
            if ((fu_op_ks ^ fu_op_ed) !== 1'b1 || fu_op_ks !== k) bus_err++;
            if (rk_idx !== er) bus_err++;
            if (r < 32 && c % 4 == 0 && fu_rs1 !== xs[r]) bus_err++;
            if (r < 32 && c % 4 == 3) xs[r + 4] = fu_result;
            if (rk_out_valid !== (k && c % 4 == 3)) bus_err++;
            if (rk_out_valid) begin
                strobes++;
                if (rk_out_idx !== 5'(r)) bus_err++;
                ks_mem[rk_out_idx] = rk_out;
            end
            @(posedge g_clk); #1;
            c++;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge g_clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ovalid_drop"}, 128'(out_valid), 128'd0);
        chk({tag, "_iready_back"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        int lat, bad;
        for (int i = 0; i < 32; i++) ks_mem[i] = '0;
        repeat (2) @(posedge g_clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_rk_out_valid", 128'(rk_out_valid), 128'd0);
        chk("rst_op_ks", 128'(fu_op_ks), 128'd0);
        chk("rst_op_ed", 128'(fu_op_ed), 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        g_rst = 1'b0;
        @(posedge g_clk); #1;
        go(1'b1, 1'b0, PT, lat);
        chk("ks_latency", 128'(lat), 128'd129);
        chk("ks_strobes", 128'(strobes), 128'd32);
        chk("ks_rk0", 128'(ks_mem[0]), 128'hF12186F9);
        chk("ks_rk31", 128'(ks_mem[31]), 128'h9124A012);
        chk("ks_bus", 128'(bus_err), 128'd0);
        handshake("ks");
        bus_err = 0;
        go(1'b0, 1'b0, PT, lat);
        chk("enc_latency", 128'(lat), 128'd129);
        chk("enc_data", out_data, CT);
        chk("enc_bus", 128'(bus_err), 128'd0);
        handshake("enc");
        bus_err = 0;
        go(1'b0, 1'b1, CT, lat);
        chk("dec_data", out_data, PT);
        chk("dec_bus_rk_idx", 128'(bus_err), 128'd0);
        in_ks = 1'b0;
        in_dec = 1'b0;
        in_data = PT;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_data", out_data, PT);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            @(posedge g_clk); #1;
        end
        out_ready = 1'b1;
        @(posedge g_clk); #1;
        out_ready = 1'b0;
        chk("bp_in_ready_after_hs", 128'(in_ready), 128'd1);
        chk("bp_not_accepted_same_cycle", 128'(fu_op_ed), 128'd0);
        @(posedge g_clk); #1;
        in_valid = 1'b0;
        chk("bp_accepted", 128'(in_ready), 128'd0);
        chk("bp_run_op_ed", 128'(fu_op_ed), 128'd1);
        repeat (28) @(posedge g_clk);
        #1;
        chk("mid_rk_idx_round7", 128'(rk_idx), 128'd7);
        g_rst = 1'b1;
        @(posedge g_clk); #1;
        g_rst = 1'b0;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        chk("mid_rst_op_ks", 128'(fu_op_ks), 128'd0);
        chk("mid_rst_op_ed", 128'(fu_op_ed), 128'd0);
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_rk_idx", 128'(rk_idx), 128'd0);
        chk("mid_rst_out_data", out_data, 128'd0);
        bad = 0;
        for (int i = 0; i < 140; i++) begin
            if (out_valid || rk_out_valid || !in_ready) bad++;
            @(posedge g_clk); #1;
        end
        chk("abandoned_job_silent", 128'(bad), 128'd0);
        bus_err = 0;
        go(1'b0, 1'b0, PT, lat);
        chk("re_enc_latency", 128'(lat), 128'd129);
        chk("re_enc_data", out_data, CT);
        chk("re_enc_bus", 128'(bus_err), 128'd0);
        handshake("re_enc");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
